wb_filter: RTL and testbench
============================

WB_FILTER -- requirements
Module: wb_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath width of every source and of the result.
REQ-002 SHALL have parameter OPW, default 5: opcode width.
REQ-003 SHALL have parameter RAW, default 3: destination register address width.
REQ-004 SHALL have parameter ALU_LO, default 4, and ALU_HI, default 13: inclusive opcode range that selects the ALU result.
REQ-005 SHALL have parameter MEM_TMO, default 15: maximum number of cycles spent in WAIT_MEM, range 1..255.
REQ-006 Ports; one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block accepts the instruction
- opcode  in  OPW  instruction opcode
- dst  in  RAW  destination register
- temp1  in  WIDTH  temp register source
- imm  in  WIDTH  immediate source
- ula  in  WIDTH  ALU result source
- mem_valid  in  1  memory read data valid
- mem_data  in  WIDTH  memory read data
- out_valid  out  1  writeback valid
- out_ready  in  1  register file accepts writeback
- out_we  out  1  write enable qualifier for the register file
- out_addr  out  RAW  registered destination
- out_data  out  WIDTH  registered writeback value
- mem_err  out  1  one-cycle pulse: memory timeout

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_MEM, HOLD.
REQ-008 SHALL drive in_ready=1 in IDLE, in_ready=out_ready in HOLD, and in_ready=0 in WAIT_MEM.
REQ-009 Accept = in_valid & in_ready; on accept, SHALL register dst into out_addr.
REQ-010 On accept with opcode 0 (LOAD), SHALL go to WAIT_MEM, clear the timeout counter, and ignore temp1, imm and ula.
REQ-011 On accept with any other opcode, SHALL go to HOLD with out_data registered the same cycle (1-cycle latency): opcode 1 -> imm; opcode 2 -> temp1; ALU_LO <= opcode <= ALU_HI -> ula; otherwise -> 0.
REQ-012 On a non-LOAD accept, SHALL set out_we=1 for opcodes 1, 2 and ALU_LO..ALU_HI, and out_we=0 for all other opcodes (out_data=0).
REQ-013 In WAIT_MEM, when mem_valid=1, SHALL capture mem_data into out_data, set out_we=1, and go to HOLD.
REQ-014 In WAIT_MEM, SHALL ignore mem_valid in every other state, and increment the counter on each cycle with mem_valid=0.
REQ-015 When the counter reaches MEM_TMO with mem_valid=0, SHALL go to HOLD with out_data=0, out_we=0, and pulse mem_err high for exactly that cycle.
REQ-016 If mem_valid=1 on the cycle the counter reaches MEM_TMO, SHALL treat mem_valid as winning: capture the data and assert no mem_err.
REQ-017 SHALL assert out_valid if and only if state is HOLD.
REQ-018 While out_valid=1 and out_ready=0, SHALL hold out_data, out_addr and out_we stable.
REQ-019 In HOLD with out_ready=1: a simultaneous accept SHALL follow REQ-010/011 directly (back-to-back, no bubble); otherwise SHALL go to IDLE.
REQ-020 SHALL be throughput-capable of one non-LOAD instruction per cycle; a LOAD SHALL take at least 2 cycles from accept to out_valid.

Reset
REQ-021 On rst=1 at a clock edge, SHALL go to IDLE, clear the counter, and clear out_valid, out_we, out_addr, out_data and mem_err to 0, overriding any in-flight LOAD or HOLD.
REQ-022 While rst=1, SHALL hold in_ready at 0; the first accept is possible on the first edge after rst deasserts.

Structure
REQ-023 State encoding (IDLE, WAIT_MEM, HOLD), opcode constants OP_LOAD=0, OP_IMM=1, OP_TEMP=2, and the default ALU range SHALL live in the shared CPU package.
REQ-024 A combinational sub-module wb_src_mux, taking the opcode and sources and returning data and a write-enable, SHALL be the only opcode decode; wb_filter SHALL instantiate it.
REQ-025 Counter width SHALL be 8 bits.

Verification
REQ-026 Reset mid-WAIT_MEM: accept opcode 0, assert rst on the 2nd cycle -> state IDLE, out_valid=0, out_data=0, no mem_err.
REQ-027 Back-to-back: opcode 1 (imm=0x3C), then opcode 5 (ula=0xA5), out_ready=1 -> out_data 0x3C then 0xA5 on consecutive cycles, out_we=1, in_ready constantly 1.
REQ-028 LOAD: accept opcode 0 with dst=4, mem_valid after 3 cycles with mem_data=0x7E -> out_valid with out_data=0x7E, out_addr=4, out_we=1.
REQ-029 Timeout: opcode 0 with MEM_TMO=15 and mem_valid never asserted -> exactly 15 WAIT_MEM cycles, mem_err pulse, out_data=0, out_we=0.
REQ-030 Stall and illegal opcode: opcode 3 with out_ready=0 for 4 cycles -> out_valid held, out_data=0, out_we=0, in_ready=0 until the release cycle.

Source files
------------

// File: rtl/wb_filter_pkg.sv
// rtl/wb_filter_pkg.sv - shared writeback-filter types, opcode constants and decode helper
package wb_filter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2
    } state_t;

    localparam int OP_LOAD    = 0;
    localparam int OP_IMM     = 1;
    localparam int OP_TEMP    = 2;
    localparam int ALU_LO_DEF = 4;
    localparam int ALU_HI_DEF = 13;
    localparam int CNT_W      = 8;

    function automatic logic in_alu_range(input int op, input int lo, input int hi);
        return (op >= lo) && (op <= hi);
    endfunction

endpackage

// File: rtl/wb_src_mux.sv
// rtl/wb_src_mux.sv - combinational opcode decode selecting writeback data and write enable
module wb_src_mux
    import wb_filter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int OPW    = 5,
    parameter int ALU_LO = ALU_LO_DEF,
    parameter int ALU_HI = ALU_HI_DEF
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] temp1,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] ula,
    output logic [WIDTH-1:0] data,
    output logic             we,
    output logic             is_load
);

    int op_num;

    always_comb begin
        op_num  = int'(opcode);
        data    = '0;
        we      = 1'b0;
        is_load = 1'b0;
        if (op_num == OP_LOAD) begin
            is_load = 1'b1;
        end else if (op_num == OP_IMM) begin
            data = imm;
            we   = 1'b1;
        end else if (op_num == OP_TEMP) begin
            data = temp1;
            we   = 1'b1;
        end else if (in_alu_range(op_num, ALU_LO, ALU_HI)) begin
            data = ula;
            we   = 1'b1;
        end
        // unrecognised opcodes fall through as a zero-data, no-write writeback
    end

endmodule

// File: rtl/wb_filter.sv
// rtl/wb_filter.sv - writeback filter: opcode source select, memory wait with timeout, output hold
module wb_filter
    import wb_filter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OPW     = 5,
    parameter int RAW     = 3,
    parameter int ALU_LO  = ALU_LO_DEF,
    parameter int ALU_HI  = ALU_HI_DEF,
    parameter int MEM_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [RAW-1:0]   dst,
    input  logic [WIDTH-1:0] temp1,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] ula,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_we,
    output logic [RAW-1:0]   out_addr,
    output logic [WIDTH-1:0] out_data,
    output logic             mem_err
);

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MEM_TMO);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0] data_nxt, mux_data;
    logic [RAW-1:0]   addr_nxt;
    logic             we_nxt, err_nxt, mux_we, mux_load, accept;

    wb_src_mux #(
        .WIDTH  (WIDTH),
        .OPW    (OPW),
        .ALU_LO (ALU_LO),
        .ALU_HI (ALU_HI)
    ) u_src_mux (
        .opcode  (opcode),
        .temp1   (temp1),
        .imm     (imm),
        .ula     (ula),
        .data    (mux_data),
        .we      (mux_we),
        .is_load (mux_load)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = out_data;
        addr_nxt  = out_addr;
        we_nxt    = out_we;
        err_nxt   = 1'b0;
        if (accept) begin
            addr_nxt = dst;
            if (mux_load) begin
                state_nxt = WAIT_MEM;
                cnt_nxt   = '0;
            end else begin
                state_nxt = HOLD;
                data_nxt  = mux_data;
                we_nxt    = mux_we;
            end
        end else begin
            case (state)
                WAIT_MEM: begin
                    // data arriving on the timeout cycle still wins over the error
                    if (mem_valid) begin
                        state_nxt = HOLD;
                        data_nxt  = mem_data;
                        we_nxt    = 1'b1;
                    end else if (cnt_inc == TMO_CNT) begin
                        state_nxt = HOLD;
                        cnt_nxt   = cnt_inc;
                        data_nxt  = '0;
                        we_nxt    = 1'b0;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HOLD: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_we   <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            out_data <= data_nxt;
            out_addr <= addr_nxt;
            out_we   <= we_nxt;
            mem_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_filter.sv
// tb/tb_wb_filter.sv - directed scoreboard bench for wb_filter
module tb_wb_filter;

    logic       clk, rst, in_valid, in_ready, mem_valid, out_valid, out_ready, out_we, mem_err;
    logic [4:0] opcode;
    logic [2:0] dst, out_addr;
    logic [7:0] temp1, imm, ula, mem_data, out_data;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
        logic       we;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    logic       s_in_ready, s_out_valid, s_out_we, s_mem_err;
    logic [2:0] s_out_addr;
    logic [7:0] s_out_data;

    wb_filter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .dst       (dst),
        .temp1     (temp1),
        .imm       (imm),
        .ula       (ula),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_t model(input int op, input logic [2:0] d,
                                  input logic [7:0] t, input logic [7:0] i, input logic [7:0] u);
        wb_t r;
        r.addr = d;
        r.data = 8'h00;
        r.we   = 1'b0;
        if (op == 1) begin
            r.data = i; r.we = 1'b1;
        end else if (op == 2) begin
            r.data = t; r.we = 1'b1;
        end else if (op >= 4 && op <= 13) begin
            r.data = u; r.we = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // samples just ahead of the rising edge, retires a writeback if one is handed off, then advances
    task automatic tick();
        wb_t e;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_we    = out_we;
        s_out_addr  = out_addr;
        s_out_data  = out_data;
        s_mem_err   = mem_err;
        if (s_out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("wb_addr", 32'(s_out_addr), 32'(e.addr));
                check("wb_data", 32'(s_out_data), 32'(e.data));
                check("wb_we", 32'(s_out_we), 32'(e.we));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int op, input logic [2:0] d,
                         input logic [7:0] t, input logic [7:0] i, input logic [7:0] u);
        in_valid = v;
        opcode   = 5'(op);
        dst      = d;
        temp1    = t;
        imm      = i;
        ula      = u;
    endtask

    int         ops[8] = '{1, 5, 2, 4, 13, 14, 3, 31};
    logic [7:0] rt, ri, ru;
    int         waits;

    initial begin
        rst = 1'b1; out_ready = 1'b1; mem_valid = 1'b0; mem_data = 8'h00;
        drive(1'b1, 1, 3'd1, 8'h11, 8'h22, 8'h33);
        @(negedge clk);
        tick();
        tick();
        check("rst_in_ready", 32'(s_in_ready), 32'd0);
        check("rst_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_out_data", 32'(s_out_data), 32'd0);
        check("rst_out_addr", 32'(s_out_addr), 32'd0);
        check("rst_out_we", 32'(s_out_we), 32'd0);
        check("rst_mem_err", 32'(s_mem_err), 32'd0);

        rst = 1'b0;
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();
        check("idle_in_ready", 32'(s_in_ready), 32'd1);

        // back-to-back stream, the first two are the imm 0x3C / ula 0xA5 pair
        for (int k = 0; k < 8; k++) begin
            rt = 8'($urandom); ri = 8'($urandom); ru = 8'($urandom);
            if (k == 0) ri = 8'h3C;
            if (k == 1) ru = 8'hA5;
            drive(1'b1, ops[k], 3'(k), rt, ri, ru);
            sb.push_back(model(ops[k], 3'(k), rt, ri, ru));
            tick();
            check("b2b_in_ready", 32'(s_in_ready), 32'd1);
            if (k > 0) check("b2b_out_valid", 32'(s_out_valid), 32'd1);
        end
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        check("b2b_drained_valid", 32'(s_out_valid), 32'd0);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // LOAD with data after three wait cycles; other sources are garbage
        drive(1'b1, 0, 3'd4, 8'hDE, 8'hAD, 8'hBE);
        tick();
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("load_wait_valid", 32'(s_out_valid), 32'd0);
            check("load_wait_in_ready", 32'(s_in_ready), 32'd0);
        end
        mem_valid = 1'b1; mem_data = 8'h7E;
        sb.push_back('{addr: 3'd4, data: 8'h7E, we: 1'b1});
        tick();
        mem_valid = 1'b0; mem_data = 8'h00;
        tick();
        check("load_out_valid", 32'(s_out_valid), 32'd1);
        check("load_mem_err", 32'(s_mem_err), 32'd0);
        tick();

        // timeout: mem_valid never arrives
        drive(1'b1, 0, 3'd6, 8'h01, 8'h02, 8'h03);
        tick();
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        sb.push_back('{addr: 3'd6, data: 8'h00, we: 1'b0});
        waits = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (s_out_valid === 1'b1) break;
            waits++;
            check("tmo_no_early_err", 32'(s_mem_err), 32'd0);
        end
        check("tmo_wait_cycles", 32'(waits), 32'd15);
        check("tmo_mem_err", 32'(s_mem_err), 32'd1);
        tick();
        check("tmo_err_pulse_end", 32'(s_mem_err), 32'd0);

        // mem_valid on the final wait cycle beats the timeout
        drive(1'b1, 0, 3'd3, 8'h00, 8'h00, 8'h00);
        tick();
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 14; k++) tick();
        mem_valid = 1'b1; mem_data = 8'h55;
        sb.push_back('{addr: 3'd3, data: 8'h55, we: 1'b1});
        tick();
        mem_valid = 1'b0;
        tick();
        check("race_out_valid", 32'(s_out_valid), 32'd1);
        check("race_mem_err", 32'(s_mem_err), 32'd0);
        tick();

        // stalled illegal opcode, with a pending instruction behind it
        out_ready = 1'b0;
        drive(1'b1, 3, 3'd5, 8'hAA, 8'hBB, 8'hCC);
        sb.push_back(model(3, 3'd5, 8'hAA, 8'hBB, 8'hCC));
        tick();
        drive(1'b1, 1, 3'd7, 8'h00, 8'h11, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_out_valid", 32'(s_out_valid), 32'd1);
            check("stall_in_ready", 32'(s_in_ready), 32'd0);
            check("stall_out_data", 32'(s_out_data), 32'd0);
            check("stall_out_we", 32'(s_out_we), 32'd0);
            check("stall_out_addr", 32'(s_out_addr), 32'd5);
        end
        out_ready = 1'b1;
        sb.push_back(model(1, 3'd7, 8'h00, 8'h11, 8'h00));
        tick();
        check("release_in_ready", 32'(s_in_ready), 32'd1);
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // reset on the second cycle of a LOAD, with data racing the reset
        drive(1'b1, 0, 3'd2, 8'h00, 8'h00, 8'h00);
        tick();
        drive(1'b0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();
        rst = 1'b1; mem_valid = 1'b1; mem_data = 8'h99;
        tick();
        check("rst_mid_in_ready", 32'(s_in_ready), 32'd0);
        rst = 1'b0; mem_valid = 1'b0;
        tick();
        check("rst_mid_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_mid_out_data", 32'(s_out_data), 32'd0);
        check("rst_mid_mem_err", 32'(s_mem_err), 32'd0);
        check("rst_mid_idle", 32'(s_in_ready), 32'd1);
        tick();
        check("rst_mid_still_idle", 32'(s_out_valid), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
